// File: rtl/add_round_key_unit.sv
// rtl/add_round_key_unit.sv - registered AddRoundKey stage with round-key store and auto round index
// Optional key zeroize port is enabled by defining ARK_ZEROIZE_EN.
module add_round_key_unit #(
  parameter int DATA_W   = 128,
  parameter int NUM_KEYS = 11,
  parameter int IDX_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
`ifdef ARK_ZEROIZE_EN
  input  logic              zeroize,
`endif
  input  logic              key_we,
  input  logic [IDX_W-1:0]  key_waddr,
  input  logic [DATA_W-1:0] key_wdata,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_state,
  input  logic [IDX_W-1:0]  in_idx,
  input  logic              in_auto,
  input  logic              mode_dec,
  input  logic              ctr_restart,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_state,
  output logic [IDX_W-1:0]  out_idx,
  output logic              err_idx
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_KEYS - 1);

  logic [DATA_W-1:0] key_q [NUM_KEYS];
  logic [DATA_W-1:0] key_d [NUM_KEYS];
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_state_q, out_state_d;
  logic [IDX_W-1:0]  out_idx_q, out_idx_d;
  logic              err_idx_q, err_idx_d;
  logic [IDX_W-1:0]  auto_idx_q, auto_idx_d;

  logic              zero_req;
  logic              accept;
  logic [IDX_W-1:0]  restart_val;
  logic [IDX_W-1:0]  auto_cur;
  logic [IDX_W-1:0]  auto_step;
  logic [IDX_W-1:0]  sel;
  logic [DATA_W-1:0] sel_key;

`ifdef ARK_ZEROIZE_EN
  assign zero_req = zeroize;
`else
  assign zero_req = 1'b0;
`endif

  assign in_ready  = !rst && (!out_valid_q || out_ready) && !zero_req;
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign out_state = out_state_q;
  assign out_idx   = out_idx_q;
  assign err_idx   = err_idx_q;

  // A restart in the same cycle as an auto beat makes the beat use the restart value.
  always_comb begin
    restart_val = mode_dec ? LAST_IDX : '0;
    auto_cur    = ctr_restart ? restart_val : auto_idx_q;
    sel         = in_auto ? auto_cur : in_idx;
    if (mode_dec) begin
      auto_step = (auto_cur == '0) ? LAST_IDX : auto_cur - IDX_W'(1);
    end else begin
      auto_step = (auto_cur == LAST_IDX) ? '0 : auto_cur + IDX_W'(1);
    end
    auto_idx_d = (accept && in_auto) ? auto_step : auto_cur;
  end

  // Out-of-range indices select no entry, so the key reads as zero.
  always_comb begin
    sel_key = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (sel == IDX_W'(i)) begin
        sel_key = key_q[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_KEYS; i++) begin
      key_d[i] = key_q[i];
      if (zero_req) begin
        key_d[i] = '0;
      end else if (key_we && key_waddr == IDX_W'(i)) begin
        key_d[i] = key_wdata;
      end
    end
  end

  always_comb begin
    out_valid_d = accept || (out_valid_q && !out_ready);
    out_state_d = out_state_q;
    out_idx_d   = out_idx_q;
    err_idx_d   = err_idx_q;
    if (accept) begin
      out_state_d = in_state ^ sel_key;
      out_idx_d   = sel;
      err_idx_d   = err_idx_q || (sel > LAST_IDX);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        key_q[i] <= '0;
      end
      out_valid_q <= 1'b0;
      out_state_q <= '0;
      out_idx_q   <= '0;
      err_idx_q   <= 1'b0;
      auto_idx_q  <= '0;
    end else begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        key_q[i] <= key_d[i];
      end
      out_valid_q <= out_valid_d;
      out_state_q <= out_state_d;
      out_idx_q   <= out_idx_d;
      err_idx_q   <= err_idx_d;
      auto_idx_q  <= auto_idx_d;
    end
  end

endmodule

// File: tb/tb_add_round_key_unit.sv
// tb/tb_add_round_key_unit.sv - scoreboard bench for add_round_key_unit
module tb_add_round_key_unit;

  logic         clk = 1'b0;
  logic         rst;
  logic         zeroize;
  logic         key_we;
  logic [3:0]   key_waddr;
  logic [127:0] key_wdata;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic [3:0]   in_idx;
  logic         in_auto;
  logic         mode_dec;
  logic         ctr_restart;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;
  logic [3:0]   out_idx;
  logic         err_idx;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  add_round_key_unit dut (
    .clk(clk), .rst(rst),
`ifdef ARK_ZEROIZE_EN
    .zeroize(zeroize),
`endif
    .key_we(key_we), .key_waddr(key_waddr), .key_wdata(key_wdata),
    .in_valid(in_valid), .in_ready(in_ready), .in_state(in_state),
    .in_idx(in_idx), .in_auto(in_auto), .mode_dec(mode_dec),
    .ctr_restart(ctr_restart), .out_valid(out_valid), .out_ready(out_ready),
    .out_state(out_state), .out_idx(out_idx), .err_idx(err_idx)
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference model and scoreboard
  logic [127:0] m_key [11];
  int           m_auto;
  logic         m_err;
  logic [131:0] exp_q [$];
  logic [127:0] log_state [$];
  logic [3:0]   log_idx [$];
  logic [127:0] last_state;
  logic [3:0]   last_idx;

  always @(negedge clk) begin
    int base, sel, rv;
    logic [131:0] e;
    logic [127:0] k;
    if (rst) begin
      for (int i = 0; i < 11; i++) m_key[i] = '0;
      m_auto = 0;
      m_err = 1'b0;
      exp_q.delete();
    end else begin
      check_eq("err_idx", {127'd0, err_idx}, {127'd0, m_err});
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_beat", 128'd1, 128'd0);
        end else begin
          e = exp_q.pop_front();
          check_eq("sb_state", out_state, e[131:4]);
          check_eq("sb_idx", {124'd0, out_idx}, {124'd0, e[3:0]});
        end
        last_state = out_state;
        last_idx   = out_idx;
        log_state.push_back(out_state);
        log_idx.push_back(out_idx);
      end
      rv   = mode_dec ? 10 : 0;
      base = ctr_restart ? rv : m_auto;
      if (in_valid && in_ready) begin
        sel = in_auto ? base : int'(in_idx);
        k = (sel < 11) ? m_key[sel] : 128'd0;
        if (sel >= 11) m_err = 1'b1;
        exp_q.push_back({in_state ^ k, sel[3:0]});
        if (in_auto) begin
          if (mode_dec) m_auto = (base == 0) ? 10 : base - 1;
          else          m_auto = (base == 10) ? 0 : base + 1;
        end else begin
          m_auto = base;
        end
      end else begin
        m_auto = base;
      end
      if (zeroize) begin
        for (int i = 0; i < 11; i++) m_key[i] = '0;
      end else if (key_we && key_waddr < 4'd11) begin
        m_key[key_waddr] = key_wdata;
      end
    end
  end

  task automatic send(input logic [127:0] st, input logic [3:0] idx, input logic au, input logic rs);
    int n;
    in_state = st; in_idx = idx; in_auto = au; ctr_restart = rs; in_valid = 1'b1;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 50) begin
        check_eq("send_timeout", 128'd1, 128'd0);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0; ctr_restart = 1'b0; in_auto = 1'b0;
  endtask

  task automatic write_key(input logic [3:0] a, input logic [127:0] d);
    key_we = 1'b1; key_waddr = a; key_wdata = d;
    @(posedge clk); #1;
    key_we = 1'b0;
  endtask

  task automatic drain;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [127:0] a_exp;
    logic [127:0] st;
    rst = 1'b1; zeroize = 1'b0; key_we = 1'b0; key_waddr = '0; key_wdata = '0;
    in_valid = 1'b0; in_state = '0; in_idx = '0; in_auto = 1'b0; mode_dec = 1'b0;
    ctr_restart = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_in_ready", {127'd0, in_ready}, 128'd0);
    check_eq("rst_out_valid", {127'd0, out_valid}, 128'd0);
    check_eq("rst_out_state", out_state, 128'd0);
    check_eq("rst_out_idx", {124'd0, out_idx}, 128'd0);
    check_eq("rst_err_idx", {127'd0, err_idx}, 128'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Round-0 known answer
    write_key(4'd0, 128'h000102030405060708090a0b0c0d0e0f);
    send(128'h00112233445566778899aabbccddeeff, 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    check_eq("kat_valid", {127'd0, out_valid}, 128'd1);
    check_eq("kat_state", out_state, 128'h00102030405060708090a0b0c0d0e0f0);
    check_eq("kat_idx", {124'd0, out_idx}, 128'd0);
    drain();

    // Auto encrypt with wrap
    for (int i = 0; i < 11; i++) write_key(4'(i), {16{8'(i)}});
    mode_dec = 1'b0; ctr_restart = 1'b1;
    @(posedge clk); #1;
    ctr_restart = 1'b0;
    log_idx.delete(); log_state.delete();
    for (int i = 0; i < 12; i++) send(128'd0, 4'd0, 1'b1, 1'b0);
    drain();
    check_eq("enc_count", 128'(log_idx.size()), 128'd12);
    for (int i = 0; i < 12 && i < log_idx.size(); i++) begin
      check_eq("enc_idx", {124'd0, log_idx[i]}, 128'(i % 11));
      check_eq("enc_state", log_state[i], {16{8'(i % 11)}});
    end

    // Auto decrypt, restart with first beat
    mode_dec = 1'b1;
    log_idx.delete(); log_state.delete();
    for (int i = 0; i < 12; i++) send(128'h55, 4'd0, 1'b1, i == 0);
    drain();
    check_eq("dec_count", 128'(log_idx.size()), 128'd12);
    for (int i = 0; i < 12 && i < log_idx.size(); i++)
      check_eq("dec_idx", {124'd0, log_idx[i]}, 128'((i <= 10) ? 10 - i : 10));
    mode_dec = 1'b0;

    // Backpressure
    log_idx.delete(); log_state.delete();
    out_ready = 1'b0;
    send(128'hA0A0, 4'd5, 1'b0, 1'b0);
    a_exp = 128'hA0A0 ^ {16{8'h05}};
    fork
      send(128'hB0B0, 4'd6, 1'b0, 1'b0);
      begin
        repeat (3) begin
          @(negedge clk);
          check_eq("bp_in_ready", {127'd0, in_ready}, 128'd0);
          check_eq("bp_state_hold", out_state, a_exp);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();
    check_eq("bp_count", 128'(log_idx.size()), 128'd2);
    if (log_idx.size() == 2) begin
      check_eq("bp_first", log_state[0], a_exp);
      check_eq("bp_second", log_state[1], 128'hB0B0 ^ {16{8'h06}});
    end

    // Write collision on entry 3
    key_we = 1'b1; key_waddr = 4'd3; key_wdata = {16{8'hC3}};
    send(128'h1234, 4'd3, 1'b0, 1'b0);
    key_we = 1'b0;
    @(negedge clk);
    check_eq("coll_old_key", out_state, 128'h1234 ^ {16{8'h03}});
    send(128'h1234, 4'd3, 1'b0, 1'b0);
    @(negedge clk);
    check_eq("coll_new_key", out_state, 128'h1234 ^ {16{8'hC3}});
    drain();

    // Bad index
    st = {4{$urandom}};
    send(st, 4'd12, 1'b0, 1'b0);
    @(negedge clk);
    check_eq("bad_state", out_state, st);
    check_eq("bad_err", {127'd0, err_idx}, 128'd1);
    send(128'h77, 4'd1, 1'b0, 1'b0);
    drain();
    check_eq("bad_err_sticky", {127'd0, err_idx}, 128'd1);

`ifdef ARK_ZEROIZE_EN
    zeroize = 1'b1; key_we = 1'b1; key_waddr = 4'd2; key_wdata = {16{8'hEE}};
    in_valid = 1'b1; in_state = 128'h99; in_idx = 4'd2;
    @(negedge clk);
    check_eq("zero_in_ready", {127'd0, in_ready}, 128'd0);
    @(posedge clk); #1;
    zeroize = 1'b0; key_we = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 11; i++) begin
      st = {4{$urandom}};
      send(st, 4'(i), 1'b0, 1'b0);
      @(negedge clk);
      check_eq("zero_state", out_state, st);
    end
    drain();
`endif

    // Reset with a held beat
    out_ready = 1'b0;
    send(128'hDEAD, 4'd1, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_in_ready", {127'd0, in_ready}, 128'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_out_valid", {127'd0, out_valid}, 128'd0);
    check_eq("mid_rst_err", {127'd0, err_idx}, 128'd0);
    out_ready = 1'b1;
    drain();
    check_eq("sb_empty", 128'(exp_q.size()), 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
